// File: rtl/branch_tag_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_tag_ctrl_if
//
// Purpose : bundles the rename-stage / resolve / alias-table signals of the
//           branch tag controller into one interface.
//
// Handshake: alloc_req is a request held by rename; alloc_ready is the
//            same-cycle acceptance. A branch is allocated exactly in a cycle
//            where alloc_req && alloc_ready, and alloc_tag is its tag.
//            resolve_valid has no back-pressure: every resolve_valid cycle
//            is consumed (or ignored when the tag is out of range).
//            branch_shootdown and fold_valid are one-way strobes to the
//            alias table, one action per cycle they are high.
//
// Signals (master = rename/resolve side, slave = controller):
//   alloc_req            m->s  predicted branch wants a tag
//   alloc_ready          s->m  allocation accepted this cycle
//   alloc_tag            s->m  tag of the accepted branch (depth+1)
//   cur_tag              s->m  tag rename uses for map/get (depth)
//   resolve_valid        m->s  a branch resolved this cycle
//   resolve_tag          m->s  tag of the resolving branch
//   resolve_mispredict   m->s  resolving branch was mispredicted
//   branch_shootdown     s->m  one-cycle invalidate pulse
//   shootdown_branch_tag s->m  snapshots with tag >= this are invalid
//   fold_valid           s->m  copy snapshot[fold_src_tag][fold_arch]
//   fold_arch            s->m  architectural index being folded
//   fold_src_tag         s->m  snapshot being folded
//   rename_stall         s->m  rename must not map/get/allocate
//   dbg_fold_state       s->m  FSM state (1 = FOLD), for observation only
// ---------------------------------------------------------------------------
interface branch_tag_ctrl_if #(
    parameter int MAX_PREDICT_DEPTH      = 4,
    parameter int MAX_PREDICT_DEPTH_BITS = 3,
    parameter int NUM_AREGS              = 32
);
    localparam int AW = $clog2(NUM_AREGS);

    logic                              alloc_req;
    logic                              alloc_ready;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] alloc_tag;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] cur_tag;
    logic                              resolve_valid;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] resolve_tag;
    logic                              resolve_mispredict;
    logic                              branch_shootdown;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag;
    logic                              fold_valid;
    logic [AW-1:0]                     fold_arch;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] fold_src_tag;
    logic                              rename_stall;
    logic                              dbg_fold_state;

    modport master (
        output alloc_req, resolve_valid, resolve_tag, resolve_mispredict,
        input  alloc_ready, alloc_tag, cur_tag, branch_shootdown,
               shootdown_branch_tag, fold_valid, fold_arch, fold_src_tag,
               rename_stall, dbg_fold_state
    );

    modport slave (
        input  alloc_req, resolve_valid, resolve_tag, resolve_mispredict,
        output alloc_ready, alloc_tag, cur_tag, branch_shootdown,
               shootdown_branch_tag, fold_valid, fold_arch, fold_src_tag,
               rename_stall, dbg_fold_state
    );
endinterface

// File: rtl/branch_tag_ctrl.sv
// ---------------------------------------------------------------------------
// branch_tag_ctrl
//
// Purpose : hands out nested branch tags, tracks which outstanding branches
//           resolved, shoots down snapshots on a mispredict, and folds the
//           deepest snapshot back into the main alias table once every
//           outstanding branch resolved correctly.
//
// Ports   : clk     - clock
//           reset   - synchronous active-high reset
//           io_bus  - branch_tag_ctrl_if.slave (see interface header)
// ---------------------------------------------------------------------------
module branch_tag_ctrl #(
    parameter int MAX_PREDICT_DEPTH      = 4,
    parameter int MAX_PREDICT_DEPTH_BITS = 3,
    parameter int NUM_AREGS              = 32
) (
    input logic               clk,
    input logic               reset,
    branch_tag_ctrl_if.slave  io_bus
);
    localparam int TB = MAX_PREDICT_DEPTH_BITS;
    localparam int AW = $clog2(NUM_AREGS);
    localparam logic [TB-1:0] MAX_TAG   = TB'(MAX_PREDICT_DEPTH);
    localparam logic [AW-1:0] LAST_ARCH = AW'(NUM_AREGS - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_FOLD = 1'b1} state_t;

    state_t                       r_state,     w_state_nxt;
    logic [TB-1:0]                r_depth,     w_depth_nxt;
    // bit k holds the resolved flag of tag k+1
    logic [MAX_PREDICT_DEPTH-1:0] r_resolved,  w_resolved_nxt;
    logic [AW-1:0]                r_fold_cnt,  w_fold_cnt_nxt;
    logic [TB-1:0]                r_fold_src,  w_fold_src_nxt;
    logic                         r_shoot,     w_shoot_nxt;
    logic [TB-1:0]                r_shoot_tag, w_shoot_tag_nxt;

    logic w_in_range;
    logic w_misp;
    logic w_ok;
    logic w_alloc;
    logic w_all_resolved;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_depth     <= '0;
            r_resolved  <= '0;
            r_fold_cnt  <= '0;
            r_fold_src  <= '0;
            r_shoot     <= 1'b0;
            r_shoot_tag <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_resolved  <= w_resolved_nxt;
            r_fold_cnt  <= w_fold_cnt_nxt;
            r_fold_src  <= w_fold_src_nxt;
            r_shoot     <= w_shoot_nxt;
            r_shoot_tag <= w_shoot_tag_nxt;
        end
    end

    always_comb begin
        w_in_range = (io_bus.resolve_tag != '0) && (io_bus.resolve_tag <= r_depth);
        w_misp     = (r_state == ST_RUN) && io_bus.resolve_valid &&
                     io_bus.resolve_mispredict && w_in_range;
        w_ok       = (r_state == ST_RUN) && io_bus.resolve_valid &&
                     !io_bus.resolve_mispredict && w_in_range;
        // Any mispredict strobe refuses allocation, even an out-of-range one,
        // so rename never has to reason about tag validity.
        w_alloc    = io_bus.alloc_req && (r_state == ST_RUN) && (r_depth < MAX_TAG) &&
                     !(io_bus.resolve_valid && io_bus.resolve_mispredict);

        w_state_nxt     = r_state;
        w_depth_nxt     = r_depth;
        w_resolved_nxt  = r_resolved;
        w_fold_cnt_nxt  = r_fold_cnt;
        w_fold_src_nxt  = r_fold_src;
        w_shoot_nxt     = 1'b0;
        w_shoot_tag_nxt = '0;
        w_all_resolved  = 1'b1;

        case (r_state)
            ST_RUN: begin
                if (w_misp) begin
                    w_depth_nxt     = io_bus.resolve_tag - TB'(1);
                    w_shoot_nxt     = 1'b1;
                    w_shoot_tag_nxt = io_bus.resolve_tag;
                    for (int k = 0; k < MAX_PREDICT_DEPTH; k++) begin
                        if (TB'(k + 1) >= io_bus.resolve_tag) w_resolved_nxt[k] = 1'b0;
                    end
                end else begin
                    for (int k = 0; k < MAX_PREDICT_DEPTH; k++) begin
                        if (w_ok && (TB'(k + 1) == io_bus.resolve_tag)) w_resolved_nxt[k] = 1'b1;
                        if (w_alloc && (TB'(k + 1) == r_depth + TB'(1))) w_resolved_nxt[k] = 1'b0;
                    end
                    if (w_alloc) w_depth_nxt = r_depth + TB'(1);
                end

                // Fold check looks at the post-update depth and flags.
                for (int k = 0; k < MAX_PREDICT_DEPTH; k++) begin
                    if ((TB'(k + 1) <= w_depth_nxt) && !w_resolved_nxt[k]) w_all_resolved = 1'b0;
                end
                if (!w_alloc && (w_depth_nxt != '0) && w_all_resolved) begin
                    w_state_nxt    = ST_FOLD;
                    w_fold_src_nxt = w_depth_nxt;
                    w_fold_cnt_nxt = '0;
                end
            end

            ST_FOLD: begin
                if (r_fold_cnt == LAST_ARCH) begin
                    // Walk complete: main table is now authoritative, drop
                    // every snapshot and return to tag 0.
                    w_state_nxt     = ST_RUN;
                    w_depth_nxt     = '0;
                    w_resolved_nxt  = '0;
                    w_fold_cnt_nxt  = '0;
                    w_shoot_nxt     = 1'b1;
                    w_shoot_tag_nxt = TB'(1);
                end else begin
                    w_fold_cnt_nxt = r_fold_cnt + AW'(1);
                end
            end

            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign io_bus.cur_tag              = r_depth;
    assign io_bus.alloc_tag            = r_depth + TB'(1);
    assign io_bus.alloc_ready          = w_alloc;
    assign io_bus.branch_shootdown     = r_shoot;
    assign io_bus.shootdown_branch_tag = r_shoot_tag;
    assign io_bus.fold_valid           = (r_state == ST_FOLD);
    assign io_bus.fold_arch            = r_fold_cnt;
    assign io_bus.fold_src_tag         = r_fold_src;
    assign io_bus.rename_stall         = (r_state == ST_FOLD);
    assign io_bus.dbg_fold_state       = (r_state == ST_FOLD);

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_tag_ctrl : directed vectors with an expected-event scoreboard.
// ---------------------------------------------------------------------------
module tb_branch_tag_ctrl;
    localparam int MPD = 4;
    localparam int TBW = 3;
    localparam int NA  = 32;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_tag_ctrl_if #(.MAX_PREDICT_DEPTH(MPD), .MAX_PREDICT_DEPTH_BITS(TBW), .NUM_AREGS(NA)) u_if ();

    branch_tag_ctrl #(.MAX_PREDICT_DEPTH(MPD), .MAX_PREDICT_DEPTH_BITS(TBW), .NUM_AREGS(NA)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (u_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  alloc_q[$];
    logic [7:0]  shoot_q[$];
    logic [15:0] fold_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // driver tasks
    task automatic drive(input logic req, input logic rv, input logic [TBW-1:0] rt, input logic rm);
        u_if.alloc_req          = req;
        u_if.resolve_valid      = rv;
        u_if.resolve_tag        = rt;
        u_if.resolve_mispredict = rm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fold(input int src);
        for (int a = 0; a < NA; a++) fold_q.push_back(16'(src * 256 + a));
    endtask

    task automatic wait_fold_done();
        int cyc = 0;
        while (u_if.rename_stall && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("fold_end_timeout", int'(u_if.rename_stall), 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (u_if.alloc_ready) begin
                if (alloc_q.size() == 0) chk("alloc_unexpected", int'(u_if.alloc_tag), -1);
                else chk("alloc_tag", int'(u_if.alloc_tag), int'(alloc_q.pop_front()));
            end
            if (u_if.branch_shootdown) begin
                if (shoot_q.size() == 0) chk("shoot_unexpected", int'(u_if.shootdown_branch_tag), -1);
                else chk("shoot_tag", int'(u_if.shootdown_branch_tag), int'(shoot_q.pop_front()));
            end
            if (u_if.fold_valid) begin
                if (fold_q.size() == 0) chk("fold_unexpected", int'(u_if.fold_arch), -1);
                else chk("fold_src_arch", int'(u_if.fold_src_tag) * 256 + int'(u_if.fold_arch),
                         int'(fold_q.pop_front()));
            end
            if (u_if.rename_stall && u_if.resolve_valid) chk("resolve_in_fold", 1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        drive(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_cur_tag",     int'(u_if.cur_tag), 0);
        chk("rst_alloc_tag",   int'(u_if.alloc_tag), 1);
        chk("rst_alloc_ready", int'(u_if.alloc_ready), 0);
        chk("rst_shootdown",   int'(u_if.branch_shootdown), 0);
        chk("rst_fold_valid",  int'(u_if.fold_valid), 0);
        chk("rst_stall",       int'(u_if.rename_stall), 0);
        reset = 1'b0;
        tick();

        // fill to max depth, 5th request refused
        for (int i = 0; i < MPD; i++) begin
            alloc_q.push_back(8'(i + 1));
            drive(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b0);
        #1;
        chk("full_alloc_ready", int'(u_if.alloc_ready), 0);
        chk("full_cur_tag", int'(u_if.cur_tag), 4);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();

        // mispredict tag 4 -> depth 3, then tag 2 -> depth 1
        shoot_q.push_back(8'd4);
        drive(1'b0, 1'b1, 3'd4, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("misp4_cur_tag", int'(u_if.cur_tag), 3);
        tick();
        shoot_q.push_back(8'd2);
        drive(1'b0, 1'b1, 3'd2, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("misp2_shoot_latency", int'(u_if.branch_shootdown), 1);
        chk("misp2_cur_tag", int'(u_if.cur_tag), 1);
        tick();
        chk("misp2_single_pulse", int'(u_if.branch_shootdown), 0);

        // depth 2; resolve 1 then 2 -> fold from snapshot 2
        alloc_q.push_back(8'd2);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("partial_resolve_no_fold", int'(u_if.rename_stall), 0);
        push_fold(2);
        shoot_q.push_back(8'd1);
        drive(1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        #1;
        chk("fold_stall", int'(u_if.rename_stall), 1);
        chk("fold_alloc_refused", int'(u_if.alloc_ready), 0);
        chk("fold_first_arch", int'(u_if.fold_arch), 0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        wait_fold_done();
        chk("fold_done_cur_tag", int'(u_if.cur_tag), 0);
        tick();

        // alloc and mispredict in the same cycle
        alloc_q.push_back(8'd1);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd1, 1'b1);
        #1;
        chk("misp_alloc_refused", int'(u_if.alloc_ready), 0);
        shoot_q.push_back(8'd1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("misp1_cur_tag", int'(u_if.cur_tag), 0);
        tick();

        // alloc and correct resolve in the same cycle -> no fold
        alloc_q.push_back(8'd1);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        alloc_q.push_back(8'd2);
        drive(1'b1, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("combo_cur_tag", int'(u_if.cur_tag), 2);
        tick();
        chk("combo_no_fold", int'(u_if.rename_stall), 0);
        push_fold(2);
        shoot_q.push_back(8'd1);
        drive(1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        wait_fold_done();
        chk("fold2_cur_tag", int'(u_if.cur_tag), 0);
        tick();

        // depth 3 fully resolved, reset at fold_arch 10
        for (int i = 0; i < 3; i++) begin
            alloc_q.push_back(8'(i + 1));
            drive(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        push_fold(3);
        shoot_q.push_back(8'd1);
        drive(1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        cyc = 0;
        while (!(u_if.fold_valid && u_if.fold_arch == 5'd10) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reach_arch10", int'(u_if.fold_arch), 10);
        reset = 1'b1;
        fold_q.delete();
        shoot_q.delete();
        alloc_q.delete();
        tick();
        reset = 1'b0;
        chk("abort_fold_valid", int'(u_if.fold_valid), 0);
        chk("abort_shootdown", int'(u_if.branch_shootdown), 0);
        chk("abort_cur_tag", int'(u_if.cur_tag), 0);
        tick();
        chk("abort_no_late_shoot", int'(u_if.branch_shootdown), 0);

        // resolves at depth 0 are ignored
        drive(1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        drive(1'b0, 1'b1, 3'd3, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("ign_shootdown", int'(u_if.branch_shootdown), 0);
        tick();
        chk("ign_stall", int'(u_if.rename_stall), 0);
        chk("ign_cur_tag", int'(u_if.cur_tag), 0);
        tick();

        chk("alloc_q_drained", alloc_q.size(), 0);
        chk("shoot_q_drained", shoot_q.size(), 0);
        chk("fold_q_drained",  fold_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
